cdma_spreader_multi: RTL and testbench
======================================

Name: cdma_spreader_multi

Overview:
Parametrised multi-user DSSS/CDMA spreader. It is the next generation of the single-user BPSK transmitter: one shared LFSR PN generator feeds N users, each with a loadable user code. Each user accepts one data bit per symbol through a valid/ready handshake and spreads it over CHIPS_PER_BIT chips as ±AMP BPSK. Outputs are the per-user chip streams and the composite summed channel that drives the channel model and receiver.

Parameters:
NUM_USERS, 2, number of user channels (≥1)
LFSR_W, 6, PN LFSR and user-code width
LFSR_SEED, 6'b101010, LFSR reset/restart value (non-zero)
LFSR_TAPS, 6'b110000, feedback tap mask (x^6+x^5+1, period 63)
CHIPS_PER_BIT, 63, chips per data bit (≥1)
OUT_W, 8, signed per-user chip width
AMP, 100, BPSK amplitude (≤ 2^(OUT_W-1)-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low = idle/abort
code_load  in  1  latch code_in into the code registers (honoured only in IDLE)
code_in  in  NUM_USERS*LFSR_W  user codes; user u at [u*LFSR_W +: LFSR_W]
s_valid  in  NUM_USERS  per-user data bit valid
s_data  in  NUM_USERS  per-user data bit
s_ready  out  NUM_USERS  per-user accept strobe
chip_out  out  NUM_USERS*OUT_W  signed per-user chip; user u at [u*OUT_W +: OUT_W]
sum_out  out  OUT_W+$clog2(NUM_USERS)  signed sum of all user chips
out_valid  out  1  chip_out/sum_out valid this cycle
sym_start  out  1  marks the first chip of a symbol, aligned with out_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pn=LFSR_SEED; chip_cnt=0; code regs=0; data regs=0; active=0. chip_out=0, sum_out=0, out_valid=0, sym_start=0, s_ready=0.
- FSM has two states:
  - IDLE→RUN on en=1.
  - RUN→IDLE on en=0.
  - Entering IDLE from RUN aborts the symbol: pn←LFSR_SEED, chip_cnt←0, active←0. Outputs are 0 and out_valid=0 from the next cycle.
- LFSR: Fibonacci. pn_next = {pn[LFSR_W-2:0], ^(pn & LFSR_TAPS)}. It advances once per RUN cycle. If pn==0, it reloads LFSR_SEED (lock-up guard).
- chip_cnt counts 0..CHIPS_PER_BIT-1 in RUN and wraps to 0.
- Handshake:
  - s_ready[u] = (state==RUN) & en & (chip_cnt==0). It is combinational and identical for all u.
  - A transfer occurs when s_valid[u] & s_ready[u]: data_u←s_data[u], active[u]←1.
  - If s_ready is high and s_valid[u]=0, then active[u]←0. User u is silent (chip 0) for that whole symbol.
  - s_valid asserted outside the boundary cycle is ignored. No buffering.
- Chip per user in cycle with state pn:
  - c_u = ^(pn & code_u)
  - chip_next_u = active ? ((d ^ c_u) ? +AMP : -AMP) : 0
  - On the boundary cycle, d and active are the values being accepted in that same cycle (bypass).
- Latency: chip_out, sum_out, out_valid and sym_start are registered, 1 cycle after the RUN cycle that computed them.
  - out_valid=1 for every RUN cycle output.
  - sym_start=1 when the computing cycle had chip_cnt==0.
- sum_out is the sign-extended sum of the chip_next values, registered in the same edge as chip_out. The width guarantees no overflow and no saturation. For NUM_USERS=1, sum_out width = OUT_W.
- code_load in IDLE: code regs←code_in at the next edge. code_load in RUN is ignored. code_load and en rising in the same cycle: the load is taken (state is still IDLE).
- Wrap-around: pn period 63 is independent of CHIPS_PER_BIT. The PN is not realigned per symbol; it restarts only on reset or abort.

Decomposition:
- Package cdma_pkg holds:
  - default constants: LFSR_SEED, LFSR_TAPS, AMP, OUT_W;
  - a chip-parity function;
  - a bpsk-map function (bit→±AMP).
- One sub-module: pn_lfsr (params W, SEED, TAPS; ports clk, rst_n, adv, restart, pn). It is reused later by the receiver despreader.

Test Plan:
- Reset: hold rst_n=0 for 100 ns, then check pn=101010, chip_out=0, sum_out=0, out_valid=0, s_ready=0. Assert rst_n=0 mid-RUN → all outputs 0 immediately.
- Spreading: codes U0=101011, U1=110101, both send bit 1, en=1.
  - First valid chip: U0 = -100 (parity(101010&101011)=1), U1 = -100 (parity(100000)=1), sum_out = -200, sym_start=1.
  - Then compare 126 chips against a reference model.
- Silent user: U1 s_valid=0 at the boundary → chip_out[U1]=0 for CHIPS_PER_BIT chips, sum_out equals chip_out[U0].
- Handshake: CHIPS_PER_BIT=4, s_valid held high → s_ready pulses every 4th RUN cycle. Bit sequence 1,0,1 produces symbols with inverted chip signs relative to the PN parity. s_valid pulsed off-boundary is not accepted.
- Abort/restart: drop en at chip 10 → out_valid=0 next cycle. Re-raise en → first chip again uses pn=101010 and sym_start=1.
- Config:
  - code_load during RUN leaves outputs unchanged.
  - code_load in IDLE with U0=000000 → U0 chip = +AMP when data=1 for all chips.
  - 63 advances return pn to 101010.

Source files
------------

// File: rtl/cdma_pkg.sv
// Shared constants, FSM state type and chip helpers for the CDMA spreader family.
package cdma_pkg;

  localparam int unsigned MaxW        = 32;
  localparam int unsigned DefLfsrW    = 6;
  localparam logic [5:0]  DefLfsrSeed = 6'b101010;
  // x^6 + x^5 + 1, maximal length (period 63)
  localparam logic [5:0]  DefLfsrTaps = 6'b110000;
  localparam int unsigned DefOutW     = 8;
  localparam int          DefAmp      = 100;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Code chip for one user: parity of the PN state masked by the user code.
  function automatic logic chip_parity(input logic [MaxW-1:0] pn, input logic [MaxW-1:0] code);
    return ^(pn & code);
  endfunction

  // BPSK symbol map: 1 -> +amp, 0 -> -amp.
  function automatic logic signed [MaxW-1:0] bpsk_map(input logic b, input int amp);
    return b ? MaxW'(amp) : MaxW'(-amp);
  endfunction

endpackage

// File: rtl/pn_lfsr.sv
// Fibonacci PN generator with restart and all-zero lock-up recovery.
module pn_lfsr
  import cdma_pkg::*;
#(
  parameter int unsigned  W    = DefLfsrW,
  parameter logic [W-1:0] SEED = W'(DefLfsrSeed),
  parameter logic [W-1:0] TAPS = W'(DefLfsrTaps)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         restart,
  output logic [W-1:0] pn
);

  logic [W-1:0] pn_q, pn_d;

  always_comb begin
    pn_d = pn_q;
    if (restart) begin
      pn_d = SEED;
    end else if (adv) begin
      if (pn_q == '0) begin
        pn_d = SEED;
      end else begin
        pn_d = {pn_q[W-2:0], ^(pn_q & TAPS)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pn_q <= SEED;
    end else begin
      pn_q <= pn_d;
    end
  end

  assign pn = pn_q;

endmodule

// File: rtl/cdma_spreader_multi.sv
// Multi-user DSSS spreader: shared PN, per-user code and data handshake, per-user and
// summed BPSK chip outputs registered one cycle after the computing RUN cycle.
module cdma_spreader_multi
  import cdma_pkg::*;
#(
  parameter int unsigned       NUM_USERS     = 2,
  parameter int unsigned       LFSR_W        = DefLfsrW,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = LFSR_W'(DefLfsrSeed),
  parameter logic [LFSR_W-1:0] LFSR_TAPS     = LFSR_W'(DefLfsrTaps),
  parameter int unsigned       CHIPS_PER_BIT = 63,
  parameter int unsigned       OUT_W         = DefOutW,
  parameter int                AMP           = DefAmp,
  localparam int unsigned      SUM_W         = OUT_W + $clog2(NUM_USERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          code_load,
  input  logic [NUM_USERS*LFSR_W-1:0]   code_in,
  input  logic [NUM_USERS-1:0]          s_valid,
  input  logic [NUM_USERS-1:0]          s_data,
  output logic [NUM_USERS-1:0]          s_ready,
  output logic [NUM_USERS*OUT_W-1:0]    chip_out,
  output logic signed [SUM_W-1:0]       sum_out,
  output logic                          out_valid,
  output logic                          sym_start
);

  localparam int unsigned    CntW    = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CHIPS_PER_BIT - 1);

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [NUM_USERS*LFSR_W-1:0]     code_q, code_d;
  logic [NUM_USERS-1:0]            active_q, active_d;
  logic [NUM_USERS-1:0]            data_q, data_d;
  logic [NUM_USERS-1:0]            act_eff, dat_eff;
  logic [NUM_USERS-1:0][OUT_W-1:0] chip_d, chip_q;
  logic signed [SUM_W-1:0]         sum_d, sum_q;
  logic                            valid_q, sym_q;
  logic [LFSR_W-1:0]               pn;
  logic                            run, abort, boundary;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en)  state_d = StRun;
      StRun:  if (!en) state_d = StIdle;
    endcase
  end

  // A RUN cycle with en low is the abort cycle: it produces no chip.
  assign run      = (state_q == StRun) && en;
  assign abort    = (state_q == StRun) && !en;
  assign boundary = run && (cnt_q == '0);
  assign s_ready  = {NUM_USERS{boundary}};

  pn_lfsr #(
    .W    (LFSR_W),
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (run),
    .restart (abort),
    .pn      (pn)
  );

  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end

    active_d = active_q;
    data_d   = data_q;
    if (abort) begin
      active_d = '0;
    end else if (boundary) begin
      active_d = s_valid;
      data_d   = (data_q & ~s_valid) | (s_data & s_valid);
    end

    code_d = code_q;
    if ((state_q == StIdle) && code_load) begin
      code_d = code_in;
    end
  end

  // Boundary cycle bypasses the accepted bit straight into the first chip.
  assign act_eff = boundary ? s_valid : active_q;
  assign dat_eff = boundary ? s_data  : data_q;

  always_comb begin
    chip_d = '0;
    sum_d  = '0;
    for (int u = 0; u < int'(NUM_USERS); u++) begin
      if (run && act_eff[u]) begin
        chip_d[u] = OUT_W'(bpsk_map(dat_eff[u] ^
                                    chip_parity(MaxW'(pn), MaxW'(code_q[u*LFSR_W +: LFSR_W])),
                                    AMP));
      end
      sum_d = sum_d + SUM_W'($signed(chip_d[u]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      code_q   <= '0;
      active_q <= '0;
      data_q   <= '0;
      chip_q   <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
      sym_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      active_q <= active_d;
      data_q   <= data_d;
      chip_q   <= chip_d;
      sum_q    <= sum_d;
      valid_q  <= run;
      sym_q    <= boundary;
    end
  end

  assign chip_out  = chip_q;
  assign sum_out   = sum_q;
  assign out_valid = valid_q;
  assign sym_start = sym_q;

endmodule

// File: tb/tb_cdma_spreader_multi.sv
// Randomised bench for cdma_spreader_multi: two instances (63 and 4 chips per bit)
// driven in lockstep and compared each cycle against a cycle-level reference model.
module tb_cdma_spreader_multi;

  localparam int NU   = 2;
  localparam int W    = 6;
  localparam int OW   = 8;
  localparam int SW   = 9;
  localparam int AMPV = 100;
  localparam int SEED = 42;  // 6'b101010

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            code_load;
  logic [NU*W-1:0] code_in;
  logic [NU-1:0]   s_valid;
  logic [NU-1:0]   s_data;

  logic [NU-1:0]    ready_a, ready_b;
  logic [NU*OW-1:0] chip_a, chip_b;
  logic [SW-1:0]    sum_a, sum_b;
  logic             valid_a, valid_b, sym_a, sym_b;

  always #5 clk = ~clk;

  cdma_spreader_multi #(.NUM_USERS(NU), .CHIPS_PER_BIT(63)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .code_load(code_load), .code_in(code_in),
    .s_valid(s_valid), .s_data(s_data), .s_ready(ready_a), .chip_out(chip_a),
    .sum_out(sum_a), .out_valid(valid_a), .sym_start(sym_a)
  );

  cdma_spreader_multi #(.NUM_USERS(NU), .CHIPS_PER_BIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .code_load(code_load), .code_in(code_in),
    .s_valid(s_valid), .s_data(s_data), .s_ready(ready_b), .chip_out(chip_b),
    .sum_out(sum_b), .out_valid(valid_b), .sym_start(sym_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int pn_tab[63];
  int cpb[2] = '{63, 4};
  bit m_run;
  int m_idx;
  int m_cnt[2];
  bit m_act[2][NU];
  bit m_dat[2][NU];
  int m_code[NU];

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int get_chip(input int i, input int u);
    logic signed [OW-1:0] v;
    v = (i == 0) ? chip_a[u*OW +: OW] : chip_b[u*OW +: OW];
    return int'(v);
  endfunction

  function automatic int get_sum(input int i);
    logic signed [SW-1:0] v;
    v = (i == 0) ? sum_a : sum_b;
    return int'(v);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_idx = 0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      for (int u = 0; u < NU; u++) begin
        m_act[i][u] = 1'b0;
        m_dat[i][u] = 1'b0;
      end
    end
    for (int u = 0; u < NU; u++) m_code[u] = 0;
  endtask

  // Called with inputs already set; predicts, clocks once, then compares.
  task automatic step();
    bit run_now;
    bit a, d, c;
    int e_chip[2][NU];
    int e_sum[2];
    bit e_sym[2];
    #1;
    run_now = m_run && en;
    for (int i = 0; i < 2; i++) begin
      e_sym[i] = run_now && (m_cnt[i] == 0);
      check_eq(i == 0 ? "ready_a" : "ready_b", i == 0 ? int'(ready_a) : int'(ready_b),
               e_sym[i] ? (1 << NU) - 1 : 0);
      e_sum[i] = 0;
      for (int u = 0; u < NU; u++) begin
        a = e_sym[i] ? s_valid[u] : m_act[i][u];
        d = e_sym[i] ? s_data[u]  : m_dat[i][u];
        c = ^(pn_tab[m_idx] & m_code[u]);
        e_chip[i][u] = (run_now && a) ? ((d ^ c) ? AMPV : -AMPV) : 0;
        e_sum[i] += e_chip[i][u];
        if (e_sym[i]) begin
          m_act[i][u] = s_valid[u];
          if (s_valid[u]) m_dat[i][u] = s_data[u];
        end
        if (m_run && !en) m_act[i][u] = 1'b0;
      end
      m_cnt[i] = run_now ? (m_cnt[i] + 1) % cpb[i] : 0;
    end
    if (!m_run && code_load) begin
      for (int u = 0; u < NU; u++) m_code[u] = int'(code_in[u*W +: W]);
    end
    m_idx = run_now ? (m_idx + 1) % 63 : 0;
    m_run = en;

    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq(i == 0 ? "valid_a" : "valid_b", i == 0 ? int'(valid_a) : int'(valid_b),
               int'(run_now));
      check_eq(i == 0 ? "sym_a" : "sym_b", i == 0 ? int'(sym_a) : int'(sym_b), int'(e_sym[i]));
      for (int u = 0; u < NU; u++) begin
        check_eq($sformatf("chip_%s_u%0d", i == 0 ? "a" : "b", u), get_chip(i, u),
                 e_chip[i][u]);
      end
      check_eq(i == 0 ? "sum_a" : "sum_b", get_sum(i), e_sum[i]);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_valid"}, i == 0 ? int'(valid_a) : int'(valid_b), 0);
      check_eq({tag, "_sym"},   i == 0 ? int'(sym_a)   : int'(sym_b),   0);
      check_eq({tag, "_chip"},  i == 0 ? int'(chip_a)  : int'(chip_b),  0);
      check_eq({tag, "_sum"},   get_sum(i), 0);
      check_eq({tag, "_ready"}, i == 0 ? int'(ready_a) : int'(ready_b), 0);
    end
  endtask

  initial begin
    logic [5:0] p;
    p = 6'b101010;
    for (int k = 0; k < 63; k++) begin
      pn_tab[k] = int'(p);
      p = {p[4:0], p[5] ^ p[4]};  // x^6 + x^5 + 1
    end

    rst_n     = 1'b0;
    en        = 1'b0;
    code_load = 1'b0;
    code_in   = '0;
    s_valid   = '0;
    s_data    = '0;
    model_reset();

    #100;
    check_eq("rst_pn_a", int'(dut_a.u_lfsr.pn), SEED);
    check_eq("rst_pn_b", int'(dut_b.u_lfsr.pn), SEED);
    check_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Codes U0=101011, U1=110101, both users send 1
    code_in   = {6'b110101, 6'b101011};
    code_load = 1'b1;
    step();
    code_load = 1'b0;
    en        = 1'b1;
    s_valid   = 2'b11;
    s_data    = 2'b11;
    step();
    step();
    check_eq("first_u0", get_chip(0, 0), -100);
    check_eq("first_u1", get_chip(0, 1), -100);
    check_eq("first_sum", get_sum(0), -200);
    check_eq("first_sym", int'(sym_a), 1);
    repeat (126) begin
      s_data = NU'($urandom);
      step();
    end

    // User 1 silent
    s_valid = 2'b01;
    repeat (70) begin
      s_data = NU'($urandom);
      step();
    end

    // Random traffic, occasional aborts and code loads
    repeat (400) begin
      en        = ($urandom % 20) != 0;
      s_valid   = NU'($urandom);
      s_data    = NU'($urandom);
      code_load = ($urandom % 8) == 0;
      code_in   = (NU*W)'($urandom);
      step();
    end
    code_load = 1'b0;

    // Abort at chip 10 and restart
    en      = 1'b1;
    s_valid = 2'b11;
    repeat (12) step();
    en = 1'b0;
    step();
    check_eq("abort_valid", int'(valid_a), 0);
    en = 1'b1;
    step();
    check_eq("restart_pn", int'(dut_a.u_lfsr.pn), SEED);
    step();
    check_eq("restart_sym", int'(sym_a), 1);

    // Zero code for U0 loaded in IDLE; code_load during RUN must be ignored
    en = 1'b0;
    step();
    code_in   = {6'b110101, 6'b000000};
    code_load = 1'b1;
    step();
    code_load = 1'b0;
    en        = 1'b1;
    s_valid   = 2'b11;
    s_data    = 2'b11;
    step();
    repeat (70) begin
      code_load = 1'b1;
      code_in   = (NU*W)'($urandom);
      step();
      check_eq("u0_zero_code", get_chip(0, 0), AMPV);
    end
    code_load = 1'b0;

    // 63 advances bring the PN back to the seed
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    repeat (63) step();
    check_eq("wrap_pn_a", int'(dut_a.u_lfsr.pn), SEED);
    check_eq("wrap_pn_b", int'(dut_b.u_lfsr.pn), SEED);

    // Asynchronous reset mid-RUN
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    check_eq("async_rst_pn", int'(dut_a.u_lfsr.pn), SEED);
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
